// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU.
// Holds the fetch state encoding, the NOP word and the default widths and addresses.
package cpu_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 16;

    localparam logic [15:0] RESET_PC_DEF   = 16'h0000;
    localparam logic [15:0] EXC_VECTOR_DEF = 16'h0040;
    localparam logic [15:0] NOP_INSTR      = 16'h0000;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        WAIT   = 2'b01,
        HALTED = 2'b10
    } fetch_state_e;

    // Instructions are 2-byte aligned, so bit 0 of a target is dropped.
    function automatic logic [15:0] alignPc(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register: instruction, PC+2 and valid flag.
// A flush forces a NOP bubble and wins over a held (write-disabled) buffer.
module if_id_buffer
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
)(
    input  logic               clock,
    input  logic               reset,
    input  logic               i_write,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pcPlus2,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pcPlus2,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pcPlus2;
    logic               r_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_instr   <= INSTR_W'(NOP_INSTR);
            r_pcPlus2 <= '0;
            r_valid   <= 1'b0;
        end else if (i_flush) begin
            r_instr <= INSTR_W'(NOP_INSTR);
            r_valid <= 1'b0;
        end else if (i_write) begin
            r_instr   <= i_instr;
            r_pcPlus2 <= i_pcPlus2;
            r_valid   <= i_valid;
        end
    end

    assign o_instr   = r_instr;
    assign o_pcPlus2 = r_pcPlus2;
    assign o_valid   = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch FSM (RUN/WAIT/HALTED), imem handshake and IF/ID buffer.
// Optional macro IF_PERF_COUNTERS_EN adds saturating fetch_count / bubble_count outputs.
module if_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                INSTR_W    = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF)
)(
    input  logic               clock,
    input  logic               reset,
    input  logic               pc_write,
    input  logic               if_id_write,
    input  logic               if_flush,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               exception,
    input  logic [ADDR_W-1:0]  exc_pc,
    input  logic               halt,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] current_instruction,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_plus2_out,
    output logic               valid_out,
    output logic [ADDR_W-1:0]  epc,
    output logic               misalign,
    output logic               halted
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        bubble_count
`else
`endif
);

    fetch_state_e      r_state;
    fetch_state_e      w_nextState;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_nextPc;
    logic [ADDR_W-1:0] w_pcPlus2;
    logic [ADDR_W-1:0] r_epc;
    logic              r_misalign;
    logic              r_reqEn;
    logic              w_req;
    logic              w_fetchDone;
    logic              w_takeRedirect;
    logic              w_bufFlush;
    logic              w_bufWrite;
    logic              w_active;

    // Requests start on the first edge after reset release and stop for good in HALTED.
    assign w_active    = (r_state != HALTED);
    assign w_req       = r_reqEn && w_active;
    assign w_fetchDone = w_req && imem_ready;
    assign w_pcPlus2   = r_pc + ADDR_W'(2);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_nextState;
            r_pc    <= w_nextPc;
        end
    end

    // Priority: exception > halt > redirect > stall > sequential fetch.
    always_comb begin
        w_nextState    = r_state;
        w_nextPc       = r_pc;
        w_takeRedirect = 1'b0;
        w_bufFlush     = 1'b0;
        case (r_state)
            RUN, WAIT: begin
                w_bufFlush = if_flush;
                if (exception) begin
                    w_nextPc    = EXC_VECTOR;
                    w_nextState = RUN;
                    w_bufFlush  = 1'b1;
                end else if (halt) begin
                    w_nextState = HALTED;
                    w_bufFlush  = 1'b1;
                end else if (redirect) begin
                    w_nextPc       = {redirect_pc[ADDR_W-1:1], 1'b0};
                    w_nextState    = RUN;
                    w_takeRedirect = 1'b1;
                    w_bufFlush     = 1'b1;
                end else begin
                    if (pc_write && w_fetchDone) begin
                        w_nextPc = w_pcPlus2;
                    end
                    w_nextState = (w_req && !imem_ready) ? WAIT : RUN;
                end
            end
            HALTED: begin
                w_nextState = HALTED;
            end
            default: begin
                w_nextState = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_reqEn    <= 1'b0;
            r_epc      <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_reqEn <= 1'b1;
            if (w_active && exception) begin
                r_epc <= exc_pc;
            end
            if (w_takeRedirect && redirect_pc[0]) begin
                r_misalign <= 1'b1;
            end
        end
    end

    assign w_bufWrite = if_id_write && w_active;

    if_id_buffer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_buffer (
        .clock     (clock),
        .reset     (reset),
        .i_write   (w_bufWrite),
        .i_flush   (w_bufFlush),
        .i_valid   (w_fetchDone),
        .i_instr   (w_fetchDone ? imem_rdata : INSTR_W'(NOP_INSTR)),
        .i_pcPlus2 (w_pcPlus2),
        .o_instr   (instr_out),
        .o_pcPlus2 (pc_plus2_out),
        .o_valid   (valid_out)
    );

`ifdef IF_PERF_COUNTERS_EN
    logic        w_loadFetch;
    logic        w_loadNop;
    logic [31:0] r_fetchCount;
    logic [31:0] r_bubbleCount;

    assign w_loadFetch = w_bufWrite && !w_bufFlush && w_fetchDone;
    assign w_loadNop   = w_bufFlush || (w_bufWrite && !w_fetchDone);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetchCount  <= '0;
            r_bubbleCount <= '0;
        end else begin
            if (w_loadFetch && (r_fetchCount != '1)) begin
                r_fetchCount <= r_fetchCount + 32'd1;
            end
            if (w_loadNop && (r_bubbleCount != '1)) begin
                r_bubbleCount <= r_bubbleCount + 32'd1;
            end
        end
    end

    assign fetch_count  = r_fetchCount;
    assign bubble_count = r_bubbleCount;
`else
`endif

    assign imem_req            = w_req;
    assign imem_addr           = r_pc;
    assign pc                  = r_pc;
    assign current_instruction = imem_ready ? imem_rdata : INSTR_W'(NOP_INSTR);
    assign epc                 = r_epc;
    assign misalign            = r_misalign;
    assign halted              = (r_state == HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by randomized control traffic,
// all checked against a rule-level fetch model.
module tb_if_stage;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pc_write = 1'b1;
    logic        if_id_write = 1'b1;
    logic        if_flush = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        exception = 1'b0;
    logic [15:0] exc_pc = '0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] pc;
    logic [15:0] current_instruction;
    logic [15:0] instr_out;
    logic [15:0] pc_plus2_out;
    logic        valid_out;
    logic [15:0] epc;
    logic        misalign;
    logic        halted;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    int errorCount = 0;
    int checkCount = 0;

    logic [15:0] mPc;
    logic [15:0] mInstr;
    logic [15:0] mPcPlus2;
    logic [15:0] mEpc;
    logic        mValid;
    logic        mMisalign;
    logic        mHalted;
    logic        mReq;

    if_stage dut (
        .clock               (clock),
        .reset               (reset),
        .pc_write            (pc_write),
        .if_id_write         (if_id_write),
        .if_flush            (if_flush),
        .redirect            (redirect),
        .redirect_pc         (redirect_pc),
        .exception           (exception),
        .exc_pc              (exc_pc),
        .halt                (halt),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_ready          (imem_ready),
        .imem_rdata          (imem_rdata),
        .pc                  (pc),
        .current_instruction (current_instruction),
        .instr_out           (instr_out),
        .pc_plus2_out        (pc_plus2_out),
        .valid_out           (valid_out),
        .epc                 (epc),
        .misalign            (misalign),
        .halted              (halted)
`ifdef IF_PERF_COUNTERS_EN
        ,
        .fetch_count         (fetch_count),
        .bubble_count        (bubble_count)
`endif
    );

    always #5 clock = ~clock;

    // Memory image: every even address holds a distinct non-NOP word.
    function automatic logic [15:0] memWord(input logic [15:0] addr);
        return addr ^ 16'hC3A5;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mPc       = 16'h0000;
        mInstr    = NOP_INSTR;
        mPcPlus2  = 16'h0000;
        mEpc      = 16'h0000;
        mValid    = 1'b0;
        mMisalign = 1'b0;
        mHalted   = 1'b0;
        mReq      = 1'b0;
    endtask

    task automatic checkRegs();
        checkOutput("pc", pc, mPc);
        checkOutput("instr_out", instr_out, mInstr);
        checkOutput("valid_out", valid_out, mValid);
        checkOutput("epc", epc, mEpc);
        checkOutput("misalign", misalign, mMisalign);
        checkOutput("halted", halted, mHalted);
        if (mValid) begin
            checkOutput("pc_plus2_out", pc_plus2_out, mPcPlus2);
        end
    endtask

    // Drives one cycle of inputs, checks combinational outputs, advances the model and
    // checks the registered outputs just after the clock edge.
    task automatic applyStimulus(input logic pw, input logic iw, input logic fl, input logic rd,
                                 input logic [15:0] rpc, input logic ex, input logic [15:0] epcIn,
                                 input logic hl, input logic rdy);
        logic [15:0] word;
        logic [15:0] fetchAddr;
        logic        fetchDone;
        logic        flushBuf;
        word = rdy ? memWord(mPc) : 16'($urandom);
        pc_write    = pw;
        if_id_write = iw;
        if_flush    = fl;
        redirect    = rd;
        redirect_pc = rpc;
        exception   = ex;
        exc_pc      = epcIn;
        halt        = hl;
        imem_ready  = rdy;
        imem_rdata  = word;
        #1;
        checkOutput("imem_req", imem_req, mReq);
        checkOutput("imem_addr", imem_addr, mPc);
        checkOutput("current_instruction", current_instruction, rdy ? word : NOP_INSTR);

        fetchDone = mReq && rdy;
        fetchAddr = mPc;
        if (!mHalted) begin
            flushBuf = fl || rd || ex || hl;
            if (ex) begin
                mPc  = EXC_VECTOR_DEF;
                mEpc = epcIn;
            end else if (hl) begin
                mHalted = 1'b1;
            end else if (rd) begin
                mPc = rpc & 16'hFFFE;
                if (rpc[0]) mMisalign = 1'b1;
            end else if (pw && fetchDone) begin
                mPc = mPc + 16'd2;
            end
            if (flushBuf) begin
                mInstr = NOP_INSTR;
                mValid = 1'b0;
            end else if (iw) begin
                if (fetchDone) begin
                    mInstr   = word;
                    mPcPlus2 = fetchAddr + 16'd2;
                    mValid   = 1'b1;
                end else begin
                    mInstr = NOP_INSTR;
                    mValid = 1'b0;
                end
            end
            mReq = !mHalted;
        end

        @(posedge clock);
        #1;
        checkRegs();
    endtask

    task automatic runPlain(input int cycles, input logic rdy);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, rdy);
        end
    endtask

    // Asserts reset shortly after an edge and releases it before the next one.
    task automatic pulseReset();
        reset = 1'b0;
        #1;
        modelReset();
        checkRegs();
        checkOutput("reset pc_plus2_out", pc_plus2_out, 16'h0000);
        checkOutput("reset imem_req", imem_req, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        int haltedCycles;
        modelReset();
        #2;
        checkRegs();
        checkOutput("reset imem_req", imem_req, 1'b0);
        checkOutput("reset pc_plus2_out", pc_plus2_out, 16'h0000);
        @(posedge clock);
        #1;
        checkOutput("held reset pc", pc, 16'h0000);
        reset = 1'b1;

        $display("[TB] sequential fetch");
        runPlain(4, 1'b1);
        checkOutput("seq pc", pc, 16'h0006);
        checkOutput("seq instr", instr_out, memWord(16'h0004));
        checkOutput("seq pc_plus2", pc_plus2_out, 16'h0006);

        $display("[TB] imem wait states");
        runPlain(3, 1'b0);
        checkOutput("wait pc", pc, 16'h0006);
        checkOutput("wait valid", valid_out, 1'b0);
        runPlain(1, 1'b1);
        checkOutput("after wait pc", pc, 16'h0008);
        checkOutput("after wait instr", instr_out, memWord(16'h0006));
        runPlain(1, 1'b1);

        $display("[TB] stall");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        end
        checkOutput("stall pc", pc, 16'h000A);
        checkOutput("stall instr", instr_out, memWord(16'h0008));
        runPlain(1, 1'b1);
        checkOutput("post stall pc", pc, 16'h000C);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("refetch pc", pc, 16'h000C);

        $display("[TB] redirect during wait");
        runPlain(1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0031, 1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("redir pc", pc, 16'h0030);
        checkOutput("redir misalign", misalign, 1'b1);
        checkOutput("redir valid", valid_out, 1'b0);
        runPlain(1, 1'b1);
        checkOutput("redir fetch", instr_out, memWord(16'h0030));

        $display("[TB] exception over redirect");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b1, 16'h0012, 1'b0, 1'b1);
        checkOutput("exc pc", pc, 16'h0040);
        checkOutput("exc epc", epc, 16'h0012);
        checkOutput("exc valid", valid_out, 1'b0);

        $display("[TB] halt");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0020, 1'b0, 16'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 1'($urandom), 1'($urandom), 16'($urandom),
                          1'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        end
        checkOutput("halt pc", pc, 16'h0020);
        checkOutput("halt flag", halted, 1'b1);
        checkOutput("halt req", imem_req, 1'b0);
        pulseReset();
        runPlain(3, 1'b1);
        checkOutput("restart pc", pc, 16'h0004);

        $display("[TB] randomized traffic");
        haltedCycles = 0;
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom % 8) != 0, ($urandom % 8) != 0, ($urandom % 16) == 0,
                          ($urandom % 12) == 0, 16'($urandom), ($urandom % 32) == 0,
                          16'($urandom), ($urandom % 80) == 0, ($urandom % 4) != 0);
            haltedCycles = mHalted ? haltedCycles + 1 : 0;
            if (haltedCycles > 5) begin
                pulseReset();
                haltedCycles = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
